intbus_arbiter: RTL and testbench
=================================

# intbus_arbiter

- Shares one internal register bus (intbus) between NMASTERS requesters, e.g. the host bridge and an on-chip snapshot/DMA sequencer.
- Grants masters round-robin and issues one single-cycle write or read strobe to the slave side.
- For reads, holds the grant until the slave's `rvalid` returns; slave read latency varies with output/rvalid flops and clock-domain sync.
- Bounds that wait with a timeout counter, so an unmapped or hung address cannot lock the bus.

## Interface

Parameters:
- `NMASTERS`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 16: bus address width.
- `DATA_WIDTH`, 32: bus data width.
- `TIMEOUT`, 64: maximum number of WAIT cycles for `s_rvalid`, ≥1.
- `TIMEOUT_DATA`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk` in 1: bus clock.
  - `resetn` in 1: synchronous reset, active low.
- Master side:
  - `m_addr` in NMASTERS*ADDR_WIDTH: per-master address; master k occupies slice k.
  - `m_wdata` in NMASTERS*DATA_WIDTH: per-master write data.
  - `m_wr` in NMASTERS: write request, level, held until `m_done[k]`.
  - `m_rd` in NMASTERS: read request, level, held until `m_done[k]`.
  - `m_done` out NMASTERS: one-cycle completion pulse to the granted master.
  - `m_rdata` out DATA_WIDTH: read data; valid with `m_done` on reads, zero otherwise.
  - `m_err` out 1: high with `m_done` when that read timed out.
- Slave side:
  - `s_addr` out ADDR_WIDTH: slave address; nonzero only in ISSUE.
  - `s_wdata` out DATA_WIDTH: slave write data; nonzero only in ISSUE for writes.
  - `s_wr` out 1: slave write strobe.
  - `s_rd` out 1: slave read strobe.
  - `s_rdata` in DATA_WIDTH: OR-combined slave read data.
  - `s_rvalid` in 1: OR-combined slave read valid.
- Status:
  - `timeout_flag` out 1: sticky; set on any timeout, cleared only by reset.
  - `late_flag` out 1: sticky; set when `s_rvalid` arrives outside ISSUE-read/WAIT, cleared only by reset.

## Operation

FSM states are IDLE, ISSUE, WAIT and DONE. All outputs are registered.

- **IDLE**
  - The candidate set is `m_wr | m_rd`.
  - The winner is the first requester after `last` in circular order.
  - Latch the winner's index, address, wdata and op into internal registers; go to ISSUE.
  - If the set is empty, stay in IDLE.
- **ISSUE** (exactly one cycle)
  - Drive `s_addr`, plus `s_wr` or `s_rd`; drive `s_wdata` for writes.
  - Update `last` to the granted index.
  - Write: go to DONE.
  - Read with `s_rvalid`=1 in this cycle: capture `s_rdata`; go to DONE.
  - Read otherwise: clear the counter; go to WAIT.
- **WAIT**
  - Slave strobes are low; the counter increments each cycle.
  - `s_rvalid`=1: capture `s_rdata`; go to DONE.
  - Counter reaches TIMEOUT−1 without `s_rvalid`: load TIMEOUT_DATA, set the error bit and `timeout_flag`; go to DONE.
- **DONE** (one cycle)
  - `m_done[idx]`=1.
  - `m_rdata` = captured data on reads, 0 on writes.
  - `m_err` = error bit.
  - Go to IDLE.
- **Master obligation:** the master drops its request on the clock edge at which it samples `m_done`, so IDLE cannot re-grant the same transfer.

Rules and boundary cases:
- **Reset:** `resetn`=0 at any clock edge forces IDLE and `last`=NMASTERS−1, so master 0 wins first. All outputs return to 0, both flags clear, the counter and latched registers clear. A transfer in flight is abandoned and `m_done` is never issued for it.
- **`m_wr` and `m_rd` both high** for the granted master: write only, completed with a single `m_done`; the read is dropped.
- **Request withdrawn before grant:** ignored. The request is sampled only in IDLE, and latched values are used afterwards.
- **`s_rvalid` outside ISSUE-read/WAIT:** sets `late_flag`; no other effect (a late response after a timeout lands here).
- **Counter width:** `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing

- A request high at edge c0 in IDLE produces ISSUE strobes in c1 and DONE in c2.
- Write latency is 2 cycles from request to `m_done`.
- Read latency:
  - Slave with same-cycle rvalid: 2 cycles.
  - Slave rvalid L cycles after the strobe: L+2 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Throughput is 1 transfer per 3 cycles (IDLE, ISSUE, DONE). Back-to-back grants to different masters alternate with no extra bubble.

## Test plan

- **Reset:** hold `resetn`=0 for 3 cycles with `m_wr`=2'b11 -> all outputs 0. Release -> master 0 issues `s_wr` at release+1, master 1 at release+4.
- **Write:** master 1 writes addr 0x0012, data 0xA5A5_0001 -> `s_wr`=1 with those values for exactly 1 cycle; `m_done`=2'b10 one cycle later; `s_addr`/`s_wdata` are 0 before and after.
- **Read latency sweep:** slave rvalid latency 0, 1 and 3, returning 0x1234_5678 -> `m_rdata`=0x1234_5678 with `m_done` at 2, 3 and 5 cycles after the request, `m_err`=0.
- **Timeout:** TIMEOUT=8 and no `s_rvalid` -> `m_done` at 10 cycles with `m_rdata`=0xDEAD_BEEF and `m_err`=1, `timeout_flag` sticky. Injecting `s_rvalid` 2 cycles later sets `late_flag`.
- **Fairness:** all masters request continuously (NMASTERS=3) -> grant order 0,1,2,0,1,2 and each master gets 1 of every 3 grants.
- **Reset mid-read:** assert `resetn`=0 during WAIT -> no `m_done`; the next request after release is served normally.

Source files
------------

// File: rtl/intbus_arbiter.sv
// intbus_arbiter: round-robin arbiter sharing one register bus between masters, with read timeout
module intbus_arbiter #(
  parameter int NMASTERS = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NMASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NMASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NMASTERS-1:0]            m_wr,
  input  logic [NMASTERS-1:0]            m_rd,
  output logic [NMASTERS-1:0]            m_done,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_err,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic                           s_wr,
  output logic                           s_rd,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic                           s_rvalid,
  output logic                           timeout_flag,
  output logic                           late_flag
);
  localparam int IW = $clog2(NMASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, idx_q, idx_d, win;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d, s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NMASTERS-1:0] req, m_done_q, m_done_d;
  logic wr_q, wr_d, err_q, err_d, tflag_q, tflag_d, late_q, late_d;
  logic s_wr_q, s_wr_d, s_rd_q, s_rd_d, m_err_q, m_err_d;

  function automatic logic [IW-1:0] rr_pick(input logic [NMASTERS-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] j;
    rr_pick = last;
    for (int i = NMASTERS; i >= 1; i--) begin
      j = IW'((int'(last) + i) % NMASTERS);
      if (r[j]) rr_pick = j;
    end
  endfunction

  assign req = m_wr | m_rd;
  assign win = rr_pick(req, last_q);
  assign m_done = m_done_q;
  assign m_rdata = m_rdata_q;
  assign m_err = m_err_q;
  assign s_addr = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wr = s_wr_q;
  assign s_rd = s_rd_q;
  assign timeout_flag = tflag_q;
  assign late_flag = late_q;

  // next state, latched transfer, and registered outputs derived from the state being entered
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    idx_d = idx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    data_d = data_q;
    err_d = err_q;
    tflag_d = tflag_q;
    late_d = late_q | (s_rvalid & ~((state_q == ISSUE & ~wr_q) | (state_q == WAIT)));
    case (state_q)
      IDLE: if (|req) begin
        idx_d = win;
        addr_d = m_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = m_wdata[win*DATA_WIDTH +: DATA_WIDTH];
        wr_d = m_wr[win];
        data_d = '0;
        err_d = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        last_d = idx_q;
        cnt_d = '0;
        data_d = (!wr_q && s_rvalid) ? s_rdata : data_q;
        state_d = (wr_q || s_rvalid) ? DONE : WAIT;
      end
      WAIT: if (s_rvalid) begin
        data_d = s_rdata;
        state_d = DONE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        data_d = TIMEOUT_DATA;
        err_d = 1'b1;
        tflag_d = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    s_addr_d = (state_d == ISSUE) ? addr_d : '0;
    s_wdata_d = (state_d == ISSUE && wr_d) ? wdata_d : '0;
    s_wr_d = state_d == ISSUE && wr_d;
    s_rd_d = state_d == ISSUE && !wr_d;
    m_done_d = (state_d == DONE) ? NMASTERS'(1) << idx_q : '0;
    m_rdata_d = (state_d == DONE && !wr_q) ? data_d : '0;
    m_err_d = state_d == DONE && err_d;
  end

  // state and output registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q <= IW'(NMASTERS - 1);
      idx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      tflag_q <= 1'b0;
      late_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      s_wr_q <= 1'b0;
      s_rd_q <= 1'b0;
      m_done_q <= '0;
      m_rdata_q <= '0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      err_q <= err_d;
      tflag_q <= tflag_d;
      late_q <= late_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wr_q <= s_wr_d;
      s_rd_q <= s_rd_d;
      m_done_q <= m_done_d;
      m_rdata_q <= m_rdata_d;
      m_err_q <= m_err_d;
    end
  end
endmodule

// File: tb/tb_intbus_arbiter.sv
// tb_intbus_arbiter: vector table plus scoreboard checks of arbitration, latency, timeout and reset
module tb_intbus_arbiter;
  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    int m;
    bit wr;
    bit rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int lat;
    logic [DW-1:0] sdata;
    logic [DW-1:0] exp_rdata;
    bit exp_err;
    int exp_lat;
  } vec_t;

  typedef struct {
    logic [NM-1:0] mask;
    logic [DW-1:0] rdata;
    logic err;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdata = '0;
  logic [NM-1:0] m_wr = '0;
  logic [NM-1:0] m_rd = '0;
  logic [NM-1:0] m_done;
  logic [DW-1:0] m_rdata;
  logic m_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic s_wr;
  logic s_rd;
  logic [DW-1:0] s_rdata = '0;
  logic s_rvalid = 1'b0;
  logic timeout_flag;
  logic late_flag;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int slave_lat = -1;
  int pend = 0;
  logic [DW-1:0] slave_data = '0;
  bit fair = 1'b0;
  logic [NM-1:0] rereq = '0;
  int grants[NM];
  exp_t sb[$];
  vec_t vecs[7];

  intbus_arbiter #(.NMASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rd(m_rd),
    .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wr(s_wr), .s_rd(s_rd), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .timeout_flag(timeout_flag), .late_flag(late_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_done(input int m, input logic [DW-1:0] rd, input logic err, input int lat);
    exp_t e;
    e.mask = NM'(1) << m;
    e.rdata = rd;
    e.err = err;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // one clock: slave response model, master request drop on m_done, scoreboard compare
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    s_rvalid = 1'b0;
    s_rdata = '0;
    if (s_rd === 1'b1) begin
      if (slave_lat == 0) begin
        s_rvalid = 1'b1;
        s_rdata = slave_data;
      end else if (slave_lat > 0) pend = slave_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        s_rvalid = 1'b1;
        s_rdata = slave_data;
      end
    end
    m_wr = m_wr | rereq;
    rereq = '0;
    if (|m_done) begin
      m_wr = m_wr & ~m_done;
      m_rd = m_rd & ~m_done;
      if (fair) rereq = m_done;
      if (sb.size() == 0) chk("unexpected_done", m_done, 0);
      else begin
        e = sb.pop_front();
        chk("done_mask", m_done, e.mask);
        chk("done_rdata", m_rdata, e.rdata);
        chk("done_err", m_err, e.err);
        chk("done_cycle", cyc, e.due);
        for (int k = 0; k < NM; k++) if (fair && m_done[k]) grants[k]++;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_wr = '0;
    m_rd = '0;
    pend = 0;
    slave_lat = -1;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    chk("pre_s_addr", s_addr, 0);
    m_addr[v.m*AW +: AW] = v.addr;
    m_wdata[v.m*DW +: DW] = v.wdata;
    m_wr[v.m] = v.wr;
    m_rd[v.m] = v.rd;
    slave_lat = v.lat;
    slave_data = v.sdata;
    expect_done(v.m, v.exp_rdata, v.exp_err, v.exp_lat);
    step();
    chk("issue_s_wr", s_wr, v.wr);
    chk("issue_s_rd", s_rd, !v.wr && v.rd);
    chk("issue_s_addr", s_addr, v.addr);
    chk("issue_s_wdata", s_wdata, v.wr ? v.wdata : 32'h0);
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      chk("done_never_seen", sb.size(), 0);
      sb.delete();
    end
    chk("done_s_addr", s_addr, 0);
    chk("done_s_wdata", s_wdata, 0);
    chk("done_s_strobe", {s_wr, s_rd}, 0);
    step();
    chk("post_done_low", m_done, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1, 1'b1, 1'b0, 16'h0012, 32'hA5A5_0001, -1, 32'h0, 32'h0, 1'b0, 2};
    vecs[1] = '{0, 1'b0, 1'b1, 16'h0020, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2};
    vecs[2] = '{2, 1'b0, 1'b1, 16'h0021, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 3};
    vecs[3] = '{1, 1'b0, 1'b1, 16'h0022, 32'h0, 3, 32'h1234_5678, 32'h1234_5678, 1'b0, 5};
    vecs[4] = '{0, 1'b1, 1'b1, 16'h00F0, 32'h1111_2222, 0, 32'h9999_9999, 32'h0, 1'b0, 2};
    vecs[5] = '{2, 1'b1, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, -1, 32'h0, 32'h0, 1'b0, 2};
    vecs[6] = '{0, 1'b0, 1'b1, 16'h0BAD, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, TO + 2};

    m_addr[0*AW +: AW] = 16'h0100;
    m_addr[1*AW +: AW] = 16'h0101;
    m_addr[2*AW +: AW] = 16'h0102;
    m_wdata[0*DW +: DW] = 32'hAAAA_0000;
    m_wdata[1*DW +: DW] = 32'hAAAA_0001;
    m_wdata[2*DW +: DW] = 32'hAAAA_0002;
    m_wr = 3'b011;
    repeat (3) step();
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_strobes", {s_wr, s_rd}, 0);
    chk("rst_m_done", m_done, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_flags", {timeout_flag, late_flag}, 0);
    resetn = 1'b1;
    expect_done(0, 32'h0, 1'b0, 2);
    expect_done(1, 32'h0, 1'b0, 5);
    step();
    chk("rel1_s_wr", s_wr, 1);
    chk("rel1_s_addr", s_addr, 16'h0100);
    step();
    step();
    step();
    chk("rel4_s_wr", s_wr, 1);
    chk("rel4_s_addr", s_addr, 16'h0101);
    step();
    chk("rel_sb_empty", sb.size(), 0);
    step();

    do_reset();
    for (int k = 0; k < NM; k++) grants[k] = 0;
    fair = 1'b1;
    m_wr = 3'b111;
    for (int i = 0; i < 6; i++) expect_done(i % NM, 32'h0, 1'b0, 2 + 3 * i);
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      step();
      n++;
    end
    m_wr = '0;
    fair = 1'b0;
    rereq = '0;
    if (sb.size() > 0) begin
      chk("fair_never_done", sb.size(), 0);
      sb.delete();
    end
    step();
    step();
    for (int k = 0; k < NM; k++) chk($sformatf("fair_grants_m%0d", k), grants[k], 2);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("timeout_flag_set", timeout_flag, 1);
    chk("late_flag_clear", late_flag, 0);
    step();
    s_rvalid = 1'b1;
    s_rdata = 32'h5555_5555;
    step();
    chk("late_flag_set", late_flag, 1);
    step();
    chk("late_flag_sticky", late_flag, 1);
    chk("timeout_flag_sticky", timeout_flag, 1);

    m_addr[0*AW +: AW] = 16'h0040;
    m_rd[0] = 1'b1;
    slave_lat = -1;
    repeat (4) step();
    chk("mid_in_wait_no_done", m_done, 0);
    resetn = 1'b0;
    m_rd = '0;
    step();
    resetn = 1'b1;
    chk("mid_rst_flags", {timeout_flag, late_flag}, 0);
    chk("mid_rst_strobes", {s_wr, s_rd}, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_rst_no_done", m_done, 0);
    end
    run_vec('{1, 1'b0, 1'b1, 16'h0033, 32'h0, 1, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 3});
    chk("end_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
